idecode_pipe: RTL

Parametrised decode stage and successor to the fixed 32x32 decode stage. It integrates the register bank, the operand and immediate extraction and the jump target, and registers all of them into an internal ID/EX pipeline register. It also adds load-use hazard detection with automatic bubble insertion, a flush input and a debug read port. It sits between IF/ID and EX and takes its control word from the external unit_control.

---
 rtl/idecode_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/idecode_pipe.sv
// idecode_pipe: decode stage with register bank, load-use hazard bubble and ID/EX register.
// Define IDECODE_WB_BYPASS_EN to make a WB write visible to same-cycle reads (write-through).
module idecode_pipe #(
  parameter int DATA_SIZE    = 32,
  parameter int INST_SIZE    = 32,
  parameter int PC_SIZE      = 32,
  parameter int REG_SIZE     = 5,
  parameter int NUM_REGS     = 32,
  parameter int CTRL_SIZE    = 16,
  parameter int MEM_READ_BIT = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_pipeline_enable,
  input  logic                 i_flush,
  input  logic [INST_SIZE-1:0] i_inst,
  input  logic [PC_SIZE-1:0]   i_pc,
  input  logic [CTRL_SIZE-1:0] i_ctrl,
  input  logic                 i_signed,
  input  logic                 i_reg_write,
  input  logic [REG_SIZE-1:0]  i_write_reg,
  input  logic [DATA_SIZE-1:0] i_write_data,
  input  logic [REG_SIZE-1:0]  i_dbg_addr,
  output logic [DATA_SIZE-1:0] o_dbg_data,
  output logic                 o_stall,
  output logic                 o_valid,
  output logic [CTRL_SIZE-1:0] o_ctrl,
  output logic [DATA_SIZE-1:0] o_data_a,
  output logic [DATA_SIZE-1:0] o_data_b,
  output logic [DATA_SIZE-1:0] o_imm,
  output logic [DATA_SIZE-1:0] o_shamt,
  output logic [REG_SIZE-1:0]  o_rs,
  output logic [REG_SIZE-1:0]  o_rt,
  output logic [REG_SIZE-1:0]  o_rd,
  output logic [PC_SIZE-1:0]   o_pc,
  output logic [PC_SIZE-1:0]   o_jump_addr
);

  logic [DATA_SIZE-1:0] regs_q [NUM_REGS];
  logic [DATA_SIZE-1:0] regs_d [NUM_REGS];

  logic                 valid_q,  valid_d;
  logic [CTRL_SIZE-1:0] ctrl_q,   ctrl_d;
  logic [DATA_SIZE-1:0] data_a_q, data_a_d;
  logic [DATA_SIZE-1:0] data_b_q, data_b_d;
  logic [DATA_SIZE-1:0] imm_q,    imm_d;
  logic [DATA_SIZE-1:0] shamt_q,  shamt_d;
  logic [REG_SIZE-1:0]  rs_q,     rs_d;
  logic [REG_SIZE-1:0]  rt_q,     rt_d;
  logic [REG_SIZE-1:0]  rd_q,     rd_d;
  logic [PC_SIZE-1:0]   pc_q,     pc_d;
  logic [PC_SIZE-1:0]   jump_q,   jump_d;

  logic [REG_SIZE-1:0]  rs_f, rt_f, rd_f;
  logic [DATA_SIZE-1:0] rd_a, rd_b;
  logic                 wr_en;
  logic                 stall;
  logic [INST_SIZE-27:0] unused_inst;

  assign rs_f        = REG_SIZE'(i_inst[25:21]);
  assign rt_f        = REG_SIZE'(i_inst[20:16]);
  assign rd_f        = REG_SIZE'(i_inst[15:11]);
  assign unused_inst = i_inst[INST_SIZE-1:26];

  assign wr_en = i_pipeline_enable & i_reg_write & (i_write_reg != '0)
               & (32'(i_write_reg) < 32'(NUM_REGS));

  function automatic logic [DATA_SIZE-1:0] rd_port(input logic [REG_SIZE-1:0] addr);
    logic [DATA_SIZE-1:0] v;
    v = '0;
    if (addr != '0 && 32'(addr) < 32'(NUM_REGS)) v = regs_q[addr];
`ifdef IDECODE_WB_BYPASS_EN
    if (wr_en && addr == i_write_reg) v = i_write_data;
`endif
    return v;
  endfunction

  always_comb begin
    rd_a       = rd_port(rs_f);
    rd_b       = rd_port(rt_f);
    o_dbg_data = rd_port(i_dbg_addr);
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[i_write_reg] = i_write_data;
  end

  // Stall is derived from ID/EX itself, so the bubble it inserts clears it next cycle.
  assign stall   = valid_q & ctrl_q[MEM_READ_BIT] & (rt_q != '0)
                 & ((rt_q == rs_f) | (rt_q == rt_f));
  assign o_stall = stall;

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    imm_d    = imm_q;
    shamt_d  = shamt_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    jump_d   = jump_q;
    if (i_pipeline_enable) begin
      valid_d  = ~(i_flush | stall);
      ctrl_d   = (i_flush | stall) ? '0 : i_ctrl;
      data_a_d = rd_a;
      data_b_d = rd_b;
      imm_d    = i_signed ? {{(DATA_SIZE-16){i_inst[15]}}, i_inst[15:0]}
                          : {{(DATA_SIZE-16){1'b0}}, i_inst[15:0]};
      shamt_d  = DATA_SIZE'(i_inst[10:6]);
      rs_d     = rs_f;
      rt_d     = rt_f;
      rd_d     = rd_f;
      pc_d     = i_pc;
      jump_d          = i_pc;
      jump_d[27:0]    = {i_inst[25:0], 2'b00};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      regs_q   <= '{default: '0};
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      pc_q     <= '0;
      jump_q   <= '0;
    end else begin
      regs_q   <= regs_d;
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      imm_q    <= imm_d;
      shamt_q  <= shamt_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      jump_q   <= jump_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_ctrl      = ctrl_q;
  assign o_data_a    = data_a_q;
  assign o_data_b    = data_b_q;
  assign o_imm       = imm_q;
  assign o_shamt     = shamt_q;
  assign o_rs        = rs_q;
  assign o_rt        = rt_q;
  assign o_rd        = rd_q;
  assign o_pc        = pc_q;
  assign o_jump_addr = jump_q;

endmodule
